// File: rtl/ram_serial_sender_pkg.sv
// ram_serial_pkg: shared FSM states and constants for the RAM-to-UART read-out path.
// RAM_SERIAL_SENDER_PARITY_EN enables the even-parity bit in every frame.
package ram_serial_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, PARITY, STOP, FINISH} state_e;
  localparam int BYTES_PER_WORD = 2;
  localparam logic UART_IDLE = 1'b1;
endpackage

// File: rtl/ram_serial_sender_uart_byte_tx.sv
// uart_byte_tx: serialises one byte as 8N1, or 8E1 when RAM_SERIAL_SENDER_PARITY_EN is defined.
// A load during the last stop-bit cycle chains the next frame with no idle gap.
module uart_byte_tx
  import ram_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       byte_end_o
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tick;
`ifdef RAM_SERIAL_SENDER_PARITY_EN
  logic          par_q, par_d;
`endif
  assign tick = timer_q == TW'(CLKS_PER_BIT - 1);
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
`ifdef RAM_SERIAL_SENDER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
`ifdef RAM_SERIAL_SENDER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  always_comb begin
    state_d    = state_q;
    timer_d    = (state_q == IDLE || tick) ? '0 : timer_q + 1'b1;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_end_o = 1'b0;
    tx_o       = UART_IDLE;
`ifdef RAM_SERIAL_SENDER_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: if (load_i) begin
        state_d = START;
        sh_d    = data_i;
`ifdef RAM_SERIAL_SENDER_PARITY_EN
        par_d   = ^data_i;
`endif
      end
      START: begin
        tx_o = 1'b0;
        if (tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        tx_o = sh_q[0];
        if (tick) begin
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 1'b1;
`ifdef RAM_SERIAL_SENDER_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef RAM_SERIAL_SENDER_PARITY_EN
      PARITY: begin
        tx_o = par_q;
        if (tick) state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        byte_end_o = 1'b1;
        state_d    = load_i ? START : IDLE;
        sh_d       = data_i;
`ifdef RAM_SERIAL_SENDER_PARITY_EN
        par_d      = ^data_i;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/ram_serial_sender.sv
// ram_serial_sender: reads word_count RAM words from address 0 and sends each as two UART bytes, low first.
// RAM_SERIAL_SENDER_PARITY_EN adds an even-parity bit to every byte frame.
module ram_serial_sender
  import ram_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              send,
  input  logic [ADDR_W:0]   word_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  state_e            state_q, state_d;
  logic [ADDR_W:0]   left_q, left_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic              sel_q, sel_d;
  logic              load, byte_end;
  logic [7:0]        load_data;
  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .sysclk    (sysclk),
    .reset     (reset),
    .load_i    (load),
    .data_i    (load_data),
    .tx_o      (tx),
    .byte_end_o(byte_end)
  );
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= IDLE;
      left_q  <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      sel_q   <= sel_d;
    end
  end
  // DATA here means "a byte of the current word is on the line"; the UART owns the bit timing.
  always_comb begin
    state_d   = state_q;
    left_d    = left_q;
    idx_d     = idx_q;
    hi_d      = hi_q;
    sel_d     = sel_q;
    load      = 1'b0;
    load_data = rd_data[7:0];
    rd_en     = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: if (send) begin
        left_d  = word_count;
        idx_d   = '0;
        state_d = (word_count == '0) ? FINISH : FETCH;
      end
      FETCH: begin
        rd_en   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        hi_d    = rd_data[15:8];
        sel_d   = 1'b0;
        load    = 1'b1;
        state_d = DATA;
      end
      DATA: if (byte_end) begin
        if (sel_q != 1'(BYTES_PER_WORD - 1)) begin
          load      = 1'b1;
          load_data = hi_q;
          sel_d     = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          left_d  = left_q - 1'b1;
          state_d = (left_q == (ADDR_W + 1)'(1)) ? FINISH : FETCH;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy    = state_q != IDLE;
  assign rd_addr = idx_q;
endmodule

// File: tb/tb_ram_serial_sender.sv
// tb_ram_serial_sender: directed checks of latency, byte order, gaps, abort, wrap and optional parity.
module tb_ram_serial_sender;
  localparam int CPB = 4;
`ifdef RAM_SERIAL_SENDER_PARITY_EN
  localparam int FR = 11 * CPB;
`else
  localparam int FR = 10 * CPB;
`endif
  localparam int WC  = 2 * FR + 2;
  localparam int LIM = 24000;

  logic        sysclk, reset, send, rd_en, tx, busy, done;
  logic [8:0]  word_count;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic [15:0] ram [256];
  logic [7:0]  rxq [$];
  logic        pq  [$];
  logic [7:0]  aq  [$];
  logic        txlog [0:LIM];
  logic        relog [0:LIM];
  logic [7:0]  exp2 [6] = '{8'h01, 8'h00, 8'h03, 8'h02, 8'h05, 8'h04};
  logic [7:0]  rx_b;
  int checks = 0, errors = 0, dcnt = 0, stop_bad = 0;

  ram_serial_sender #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .DATA_W(16)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .send      (send),
    .word_count(word_count),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (rd_en === 1'b1) begin
      rd_data <= ram[rd_addr];
      aq.push_back(rd_addr);
    end
    if (done === 1'b1) dcnt <= dcnt + 1;
  end

  // Line receiver: mid-bit sampling on the falling edge.
  always begin
    @(negedge sysclk);
    if (tx === 1'b0) begin
      repeat (CPB / 2) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge sysclk);
        rx_b[i] = tx;
      end
`ifdef RAM_SERIAL_SENDER_PARITY_EN
      repeat (CPB) @(negedge sysclk);
      pq.push_back(tx);
`endif
      repeat (CPB) @(negedge sysclk);
      if (tx !== 1'b1) stop_bad++;
      rxq.push_back(rx_b);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [8:0] wc, input int inj_t, output int dt, output int tl);
    int nb;
    nb = 0;
    tl = 0;
    dt = -1;
    word_count = wc;
    send = 1'b1;
    @(negedge sysclk);
    send = 1'b0;
    for (int t = 1; t <= LIM; t++) begin
      txlog[t] = tx;
      relog[t] = rd_en;
      if (busy !== 1'b1) nb++;
      if (tx !== 1'b1) tl++;
      if (t == inj_t) begin
        send = 1'b1;
        word_count = 9'd5;
      end else send = 1'b0;
      if (done === 1'b1) begin
        dt = t;
        break;
      end
      @(negedge sysclk);
    end
    send = 1'b0;
    chk("busy_during", nb, 0);
    @(negedge sysclk);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
  endtask

  initial begin
    int dt, tl, rb, ab, db, pb;
    reset = 1'b1;
    send = 1'b0;
    word_count = '0;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0;
    repeat (3) @(negedge sysclk);
    chk("rst_tx", tx, 1);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge sysclk);

    ram[0] = 16'hA55A;
    rb = rxq.size(); ab = aq.size(); db = dcnt;
    go(9'd1, 0, dt, tl);
    chk("t1_done_cycle", dt, 1 + WC);
    chk("t1_rd_en_n1", relog[1], 1);
    chk("t1_tx_n2", txlog[2], 1);
    chk("t1_start_n3", txlog[3], 0);
    chk("t1_reads", aq.size() - ab, 1);
    chk("t1_addr", aq[ab], 0);
    chk("t1_byte0", rxq[rb], 8'h5A);
    chk("t1_byte1", rxq[rb + 1], 8'hA5);
    chk("t1_dones", dcnt - db, 1);

    ram[0] = 16'h0001; ram[1] = 16'h0203; ram[2] = 16'h0405;
    rb = rxq.size(); ab = aq.size();
    go(9'd3, 0, dt, tl);
    chk("t2_done_cycle", dt, 1 + 3 * WC);
    chk("t2_nbytes", rxq.size() - rb, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_byte%0d", i), rxq[rb + i], exp2[i]);
    for (int i = 0; i < 3; i++) chk($sformatf("t2_addr%0d", i), aq[ab + i], i);
    chk("t2_stop_end", txlog[2 + 2 * FR], 1);
    chk("t2_gap0", txlog[3 + 2 * FR], 1);
    chk("t2_gap1", txlog[4 + 2 * FR], 1);
    chk("t2_next_start", txlog[5 + 2 * FR], 0);

    ab = aq.size(); db = dcnt;
    go(9'd0, 0, dt, tl);
    chk("t3_done_cycle", dt, 1);
    chk("t3_tx_low", tl, 0);
    chk("t3_rd_en", relog[1], 0);
    chk("t3_reads", aq.size() - ab, 0);
    chk("t3_dones", dcnt - db, 1);

    rb = rxq.size(); ab = aq.size(); db = dcnt;
    go(9'd2, 20, dt, tl);
    chk("t4_done_cycle", dt, 1 + 2 * WC);
    chk("t4_nbytes", rxq.size() - rb, 4);
    chk("t4_last_byte", rxq[rb + 3], 8'h02);
    chk("t4_reads", aq.size() - ab, 2);
    chk("t4_dones", dcnt - db, 1);
    chk("stop_bits", stop_bad, 0);

    db = dcnt;
    word_count = 9'd3;
    send = 1'b1;
    @(negedge sysclk);
    send = 1'b0;
    repeat (99) @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    chk("t5_tx", tx, 1);
    chk("t5_busy", busy, 0);
    chk("t5_rd_en", rd_en, 0);
    chk("t5_done", done, 0);
    repeat (2) @(negedge sysclk);
    reset = 1'b0;
    repeat (60) @(negedge sysclk);
    chk("t5_no_done", dcnt - db, 0);
    ram[0] = 16'hA55A;
    rb = rxq.size(); ab = aq.size();
    go(9'd1, 0, dt, tl);
    chk("t5_restart_addr", aq[ab], 0);
    chk("t5_restart_byte", rxq[rb], 8'h5A);
    chk("t5_done_cycle", dt, 1 + WC);

`ifdef RAM_SERIAL_SENDER_PARITY_EN
    ram[0] = 16'h0307;
    rb = rxq.size(); pb = pq.size();
    go(9'd1, 0, dt, tl);
    chk("t6_byte0", rxq[rb], 8'h07);
    chk("t6_byte1", rxq[rb + 1], 8'h03);
    chk("t6_par0", pq[pb], 1);
    chk("t6_par1", pq[pb + 1], 0);
    chk("t6_done_cycle", dt, 91);
`endif

    for (int i = 0; i < 256; i++) ram[i] = {~8'(i), 8'(i)};
    rb = rxq.size(); ab = aq.size();
    go(9'd256, 0, dt, tl);
    chk("t7_done_cycle", dt, 1 + 256 * WC);
    chk("t7_reads", aq.size() - ab, 256);
    chk("t7_first_addr", aq[ab], 0);
    chk("t7_last_addr", aq[ab + 255], 8'hFF);
    chk("t7_nbytes", rxq.size() - rb, 512);
    chk("t7_word1_hi", rxq[rb + 3], 8'hFE);
    chk("t7_last_lo", rxq[rb + 510], 8'hFF);
    chk("t7_last_hi", rxq[rb + 511], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_serial_sender.md
Name: ram_serial_sender

Overview:
Downstream read-out stage of the serial capture path. On a send request it walks the word RAM from address 0 up to the stored-word count and reads each 16-bit word. Each word is transmitted as two 8N1 UART bytes on a serial line, low byte first. Raises busy for the whole transfer and pulses done at the end.

Parameters:
CLKS_PER_BIT, 16, sysclk cycles per UART bit (min 2)
ADDR_W, 8, RAM address width
DATA_W, 16, RAM word width (fixed two bytes per word)

Ports:
sysclk  in  1  system clock
reset  in  1  synchronous active-high reset
send  in  1  start request; sampled only in IDLE
word_count  in  ADDR_W+1  number of words to send (0..2^ADDR_W)
rd_en  out  1  RAM read strobe
rd_addr  out  ADDR_W  RAM read address
rd_data  in  DATA_W  RAM read data, valid 1 cycle after rd_en
tx  out  1  serial output, idle high
busy  out  1  high from accept of send until done
done  out  1  single-cycle completion pulse

Behaviour:
- Interface: reset is synchronous, active-high; clock is sysclk.
- Reset values: tx=1, rd_en=0, rd_addr=0, busy=0, done=0, FSM=IDLE, all counters 0.
- Reset mid-transfer aborts immediately: tx=1 on the next edge; no done pulse.
- IDLE: send=1 latches word_count into words_left and sets busy=1.
  - words_left==0: go to FINISH; no RAM read, no tx activity.
  - otherwise: go to FETCH.
- send while busy is ignored. word_count changes after accept are ignored.
- FETCH: rd_en=1 for one cycle with rd_addr=word index.
- WAIT: rd_en=0. Next cycle, capture rd_data into the shift word and set byte_sel=0.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - byte_sel=0 sends rd_data[7:0]; byte_sel=1 sends rd_data[15:8].
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - If byte_sel=0: set byte_sel=1 and go to START. Back-to-back, no extra idle.
  - Else: increment word index and decrement words_left.
    - words_left now 0: go to FINISH.
    - otherwise: go to FETCH.
- FINISH: done=1 for one cycle, busy=0 on the following edge, return to IDLE.
- Latency: send sampled at edge N; rd_en high in cycle N+1; first start-bit cycle is N+3.
- Gap between words: 2 tx-high cycles (FETCH + WAIT) after the stop bit.
- Word index is ADDR_W bits. word_count=2^ADDR_W sends addresses 0..2^ADDR_W-1; the index wraps to 0 harmlessly after the last word.
- Bit counter width: clog2(CLKS_PER_BIT). Terminal count is CLKS_PER_BIT-1.

Optional Feature:
- Macro: RAM_SERIAL_SENDER_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 11 bits.
- Undefined: 8N1, 10-bit frame; no parity logic synthesised.

Decomposition:
- Shared package ram_serial_pkg holds:
  - FSM state enum (IDLE, FETCH, WAIT, START, DATA, PARITY, STOP, FINISH)
  - BYTES_PER_WORD=2
  - UART_IDLE=1'b1
- One natural sub-module, uart_byte_tx: serialises one byte with load/ready handshake and owns the bit timer and optional parity.
- Top level keeps the RAM sequencing, word/byte counters and busy/done.

Test Plan:
1. CLKS_PER_BIT=4, word_count=1, RAM[0]=16'hA55A, send pulse -> rd_en at N+1 with addr 0. tx decodes byte 8'h5A then 8'hA5, each 40 cycles. done pulses once at the end; busy is low afterwards.
2. word_count=3, RAM[0..2]=16'h0001/16'h0203/16'h0405 -> bytes 01,00,03,02,05,04 in order. rd_addr sequence is 0,1,2. Exactly 2 idle cycles between words.
3. word_count=0, send -> busy high 1 cycle, done pulse, rd_en never asserted, tx stays 1.
4. Second send pulse during transfer, and word_count changed mid-transfer -> ignored; byte count still matches the original latched count.
5. Reset asserted during a data bit of word 1 -> next edge tx=1, busy=0, rd_en=0, no done. A new send restarts from addr 0.
6. With RAM_SERIAL_SENDER_PARITY_EN, RAM[0]=16'h0307 -> parity bit 1 after 8'h07 and 0 after 8'h03. Frame is 44 cycles at CLKS_PER_BIT=4.
